alu: RTL and testbench
======================

# alu

Registered 3-bit signed arithmetic unit for the logic calculator datapath. It sits between the operand/opcode input stage and the result display logic. It takes two 3-bit two's-complement operands and a 2-bit operation select, and produces a 5-bit two's-complement result. Zero, sign and divide-by-zero flags accompany the result.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- in_valid  in  1  operands and select are sampled on this clock edge.
- A  in  3  operand A, two's complement, -4..3.
- B  in  3  operand B, two's complement, -4..3.
- S  in  2  operation select: 00 add, 01 subtract (A-B), 10 multiply, 11 remainder (A rem B).
- R  out  5  result, two's complement.
- SF  out  1  sign flag, equals R[4].
- ZF  out  1  zero flag, R == 0 for a valid, non-div-by-zero result.
- DZF  out  1  divide-by-zero flag: S=11 and B=0.
- out_valid  out  1  R and the flags hold a new result this cycle.

## Operation
- Sign-extend A and B to 6 bits, then compute the selected operation at 6-bit width.
- Add: range -8..6, exact in 5 bits.
- Subtract: range -7..7, exact in 5 bits.
- Multiply: range -12..16.
  - R is the low 5 bits of the product.
  - The single out-of-range case, (-4)*(-4)=16, wraps to 5'b10000 and gives SF=1. This is the accepted behaviour.
- Remainder:
  - Truncating signed remainder; the result takes the sign of A and |R| < |B|.
  - Examples: 3 rem -2 = 1, -3 rem 2 = -1, -4 rem -1 = 0.
- Divide by zero (S=11, B=0): R=0, DZF=1, ZF=0, SF=0.
- Flags:
  - SF = R[4].
  - ZF = (R==0) && !DZF.
  - DZF is only ever 1 for S=11.

## Timing
- Latency is 1 cycle. Sampling with in_valid=1 at edge n gives R, the flags and out_valid=1 after edge n, held for one cycle.
- in_valid=0 at an edge: out_valid goes to 0, and R and the flags hold their previous values.
- Back-to-back: in_valid may be high every cycle, giving one result per cycle with no stall and no ready signal.
- Reset (asynchronous assert, synchronous release):
  - R=0, SF=0, ZF=0, DZF=0, out_valid=0 immediately on rst_n low, regardless of the clock.
  - An operation in flight when reset asserts is discarded.
- Inputs must be stable around the sampling edge only. All arithmetic is combinational from registered or sampled inputs, and output registers are loaded directly.

## Structure
- Shared package alu_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_REM=2'b11.
  - width constants OPND_W=3, RES_W=5.
- One sub-module, alu_rem: combinational signed truncating remainder with a div-by-zero output.
  - Implemented as restoring division on magnitudes, not with the % operator.
- Top level: opcode mux, flag generation, output registers, valid pipeline.

## Test plan
- Reset: hold rst_n=0 mid-run with in_valid=1 -> all outputs 0 asynchronously; the first result appears 1 cycle after the first sampled in_valid following release.
- Add/sub: A=3,B=3,S=00 -> R=00110,SF=0,ZF=0. A=-4,B=3,S=01 -> R=11001 (-7),SF=1. A=2,B=2,S=01 -> R=0,ZF=1.
- Multiply: A=-3,B=3,S=10 -> R=10111 (-9),SF=1. A=-4,B=-4 -> R=10000 (wrap). A=0,B=-2 -> ZF=1.
- Remainder: A=3,B=-2 -> R=1. A=-3,B=2 -> R=11111. A=-4,B=-1 -> R=0,ZF=1,DZF=0.
- Divide by zero: A=-3,B=0,S=11 -> R=0,DZF=1,ZF=0,SF=0. Then A=-3,B=0,S=00 -> R=-3,DZF=0.
- Exhaustive sweep: all S, A, B in -4..3, back-to-back with in_valid=1 -> every result matches the reference model one cycle later, out_valid continuous.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, result bundle and helpers for the 3-bit signed ALU.
// Imported by alu and alu_rem.
package alu_pkg;

    localparam int OPND_W = 3;
    localparam int RES_W  = 5;
    localparam int EXT_W  = 6;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_REM = 2'b11;

    typedef struct packed {
        logic [RES_W-1:0] r;
        logic             sf;
        logic             zf;
        logic             dzf;
    } alu_res_t;

    function automatic logic signed [EXT_W-1:0] sext(
        input logic [OPND_W-1:0] v
    );
        return {{(EXT_W-OPND_W){v[OPND_W-1]}}, v};
    endfunction

    function automatic logic [OPND_W-1:0] mag(
        input logic [OPND_W-1:0] v
    );
        return v[OPND_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/alu_rem.sv
// Signed truncating remainder via restoring division on magnitudes.
// Result takes the sign of the dividend; dz flags a zero divisor.
module alu_rem
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [RES_W-1:0]  r,
    output logic              dz
);

    logic [OPND_W-1:0] mag_a;
    logic [OPND_W-1:0] mag_b;
    logic [OPND_W:0]   part;
    logic [RES_W-1:0]  r_mag;

    assign mag_a = mag(a);
    assign mag_b = mag(b);
    assign dz    = (b == '0);

    always_comb begin
        part = '0;
        for (int i = OPND_W - 1; i >= 0; i--) begin
            part = {part[OPND_W-1:0], mag_a[i]};
            if (part >= {1'b0, mag_b})
                part = part - {1'b0, mag_b};
        end
    end

    // |rem| < |b| <= 4, so the low bits always hold the magnitude
    assign r_mag = {{(RES_W-OPND_W){1'b0}}, part[OPND_W-1:0]};

    always_comb begin
        r = '0;
        if (!dz)
            r = a[OPND_W-1] ? (~r_mag + 1'b1) : r_mag;
    end

endmodule

// File: rtl/alu.sv
// Registered 3-bit signed ALU: add, sub, mul, rem with SF/ZF/DZF.
// One-cycle latency, one result per cycle, async active-low reset.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [OPND_W-1:0] A,
    input  logic [OPND_W-1:0] B,
    input  logic [1:0]        S,
    output logic [RES_W-1:0]  R,
    output logic              SF,
    output logic              ZF,
    output logic              DZF,
    output logic              out_valid
);

    logic signed [EXT_W-1:0] a_x;
    logic signed [EXT_W-1:0] b_x;
    logic [RES_W-1:0] sum;
    logic [RES_W-1:0] dif;
    logic [RES_W-1:0] prd;
    logic [RES_W-1:0] rem_r;
    logic             rem_dz;

    logic is_add;
    logic is_sub;
    logic is_mul;
    logic is_rem;

    alu_res_t nxt;
    alu_res_t res_q;
    logic     vld_q;

    assign a_x = sext(A);
    assign b_x = sext(B);

    // (-4)*(-4) = 16 deliberately wraps to 5'b10000
    assign sum = RES_W'(a_x + b_x);
    assign dif = RES_W'(a_x - b_x);
    assign prd = RES_W'(a_x * b_x);

    alu_rem u_rem (
        .a  (A),
        .b  (B),
        .r  (rem_r),
        .dz (rem_dz)
    );

    assign is_add = (S == OP_ADD);
    assign is_sub = (S == OP_SUB);
    assign is_mul = (S == OP_MUL);
    assign is_rem = (S == OP_REM);

    always_comb begin
        nxt = '0;
        unique case (1'b1)
            is_add: nxt.r = sum;
            is_sub: nxt.r = dif;
            is_mul: nxt.r = prd;
            is_rem: begin
                nxt.r   = rem_r;
                nxt.dzf = rem_dz;
            end
            default: nxt.r = '0;
        endcase
        nxt.sf = nxt.r[RES_W-1];
        nxt.zf = (nxt.r == '0) && !nxt.dzf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid)
                res_q <= nxt;
        end
    end

    assign R         = res_q.r;
    assign SF        = res_q.sf;
    assign ZF        = res_q.zf;
    assign DZF       = res_q.dzf;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors, reset checks and a
// back-to-back sweep against an integer reference model.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] A = '0;
    logic [2:0] B = '0;
    logic [1:0] S = '0;
    logic [4:0] R;
    logic       SF;
    logic       ZF;
    logic       DZF;
    logic       out_valid;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .S         (S),
        .R         (R),
        .SF        (SF),
        .ZF        (ZF),
        .DZF       (DZF),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        int         a;
        int         b;
        int         s;
        logic [7:0] exp;
    } exp_t;

    typedef struct {
        int         a;
        int         b;
        int         s;
        logic [7:0] exp;
    } vec_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   next_id = 0;

    // {R, SF, ZF, DZF}
    function automatic logic [7:0] ref_model(int a, int b, int s);
        int v;
        logic [4:0] r;
        logic dz;
        dz = 1'b0;
        case (s)
            0: v = a + b;
            1: v = a - b;
            2: v = a * b;
            default: begin
                if (b == 0) begin
                    dz = 1'b1;
                    v = 0;
                end else begin
                    v = a % b;
                end
            end
        endcase
        r = v[4:0];
        return {r, r[4], (r == 5'd0) && !dz, dz};
    endfunction

    task automatic send(int a, int b, int s, logic [7:0] exp);
        exp_t e;
        @(negedge clk);
        A = a[2:0];
        B = b[2:0];
        S = s[1:0];
        in_valid = 1'b1;
        e.id = next_id;
        e.a = a;
        e.b = b;
        e.s = s;
        e.exp = exp;
        next_id++;
        q.push_back(e);
    endtask

    task automatic check(string name, logic [8:0] act, logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got {R,SF,ZF,DZF,vld}=%b want %b",
                     name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out got R=%b flags=%b%b%b want none",
                         R, SF, ZF, DZF);
            end else begin
                e = q.pop_front();
                if ({R, SF, ZF, DZF} !== e.exp) begin
                    n_bad++;
                    $display("FAIL vec%0d a=%0d b=%0d s=%0d got %b want %b",
                             e.id, e.a, e.b, e.s, {R, SF, ZF, DZF}, e.exp);
                end
            end
        end
    end

    vec_t dir[$];

    initial begin
        dir.push_back('{ 3,  3, 0, 8'b00110_000});
        dir.push_back('{-4,  3, 1, 8'b11001_100});
        dir.push_back('{ 2,  2, 1, 8'b00000_010});
        dir.push_back('{-3,  3, 2, 8'b10111_100});
        dir.push_back('{-4, -4, 2, 8'b10000_100});
        dir.push_back('{ 0, -2, 2, 8'b00000_010});
        dir.push_back('{ 3, -2, 3, 8'b00001_000});
        dir.push_back('{-3,  2, 3, 8'b11111_100});
        dir.push_back('{-4, -1, 3, 8'b00000_010});
        dir.push_back('{ 3, -4, 3, 8'b00011_000});
        dir.push_back('{-4,  3, 3, 8'b11111_100});
        dir.push_back('{-4,  2, 3, 8'b00000_010});
        dir.push_back('{-3,  0, 3, 8'b00000_001});
        dir.push_back('{-3,  0, 0, 8'b11101_100});

        #1;
        check("reset_init", {R, SF, ZF, DZF, out_valid}, 9'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        foreach (dir[i])
            send(dir[i].a, dir[i].b, dir[i].s, dir[i].exp);

        // idle cycle: outputs hold the last result, valid drops
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("hold_idle", {R, SF, ZF, DZF, out_valid}, {8'b11101_100, 1'b0});

        // reset mid-run with an operation in flight
        @(negedge clk);
        A = 3'd3;
        B = 3'd3;
        S = 2'd0;
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_async", {R, SF, ZF, DZF, out_valid}, 9'b0);
        @(posedge clk);
        #1;
        check("reset_held", {R, SF, ZF, DZF, out_valid}, 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            exp_t e;
            e.id = next_id;
            e.a = 3;
            e.b = 3;
            e.s = 0;
            e.exp = 8'b00110_000;
            next_id++;
            q.push_back(e);
        end
        #1;
        check("release_novld", {R, SF, ZF, DZF, out_valid}, 9'b0);

        for (int s = 0; s < 4; s++)
            for (int a = -4; a < 4; a++)
                for (int b = -4; b < 4; b++)
                    send(a, b, s, ref_model(a, b, s));

        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout got %0d pending want 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
